rtmc_mchan_ctrl: RTL and testbench
==================================

// Module: rtmc_mchan_ctrl
// PURPOSE
//  Multi-channel stepper-motor controller behind the SPI register bus.
//  Parametrised in channel count and data width. Adds half/full-step modes,
//  step counting, signed position tracking, an emergency stop from gpi[0]
//  and a done interrupt. Sits between rtmc_spi (register bus master) and the pads.
// PARAMETERS
//  ADDR_W  8   register address width
//  DATA_W  16  register data width; also the width of the timer, count and position fields
//  NCH     2   number of motor channels, 1..63
//  PH_W    4   coil outputs per channel; fixed at 4
// PORTS
//  clk       in   1           system clock
//  rst       in   1           synchronous active-high reset
//  reg_addr  in   ADDR_W      register address
//  reg_wdat  in   DATA_W      write data
//  reg_wr    in   1           write strobe, one-cycle pulse
//  reg_rd    in   1           read strobe, one-cycle pulse
//  reg_rdat  out  DATA_W      read data; valid only while reg_ack=1
//  reg_ack   out  1           access acknowledge, one-cycle pulse
//  gpi       in   4           async inputs; gpi[0] is the e-stop
//  gpo       out  4           general outputs
//  mc        out  NCH*PH_W    coil drive; channel c occupies [c*4+:4]
//  mc_oe     out  NCH*PH_W    coil output enables
//  irq       out  1           OR of all per-channel DONE flags
// BEHAVIOUR
//  Reset: clk and rst are the only clock/reset. All registers clear to 0.
//   reg_ack=0, reg_rdat=0, gpo=0, mc=0, mc_oe=0, irq=0.
//   A reset asserted mid-step aborts the step; the block is idle on the next cycle.
//  Register bus
//   reg_ack pulses exactly 1 cycle after reg_wr or reg_rd. reg_rdat is registered with the ack.
//   If reg_wr and reg_rd arrive together: the write is performed, one ack, rdat=0.
//   Unmapped reads return 0 and are still acked.
//  Register map
//   Channel c registers live at addr = 4*c + r:
//    r=0 CTRL   [0]dir(1=reverse) [1]half(1=half-step) [2]oe [3]hold.
//     A write with half=0 clears phase-index bit0.
//    r=1 PERIOD  clocks per step; 0 is treated as 1.
//    r=2 COUNT   write: load remaining steps, restart the timer, set busy if nonzero.
//                Writing 0 stops the channel with no DONE. Read: remaining steps.
//    r=3 STATUS  read: [0]busy [1]done [2]estop [7:5]phase index.
//                Reading clears done and estop.
//                Write: any data zeroes the position counter.
//   addr 0xFE: read position of channel 0. addr 0xFF GPIO: read {gpo, gpi_sync}; write gpo.
//  Step engine (per channel)
//   While busy, the timer counts PERIOD-1 down to 0. At 0: take one step, remaining -= 1,
//    reload the timer.
//   Step: phase index moves by +/-1 (half) or +/-2 (full), modulo 8.
//    Position moves by +/-1 (signed, wraps).
//   Phase table, index 0..7: 1000,1100,0100,0110,0010,0011,0001,1001.
//   When remaining reaches 0: busy clears and done sets on the same edge.
//    A COUNT write in that same cycle wins: busy stays set and done is not set.
//   CTRL and PERIOD writes while busy take effect from the next step; the timer is not reset.
//  Outputs
//   mc = table[idx] when (busy | hold), else 0000. mc_oe = {4{oe}}. irq = |done.
//  E-stop
//   gpi is synchronised through 2 flops. A rising edge on synced gpi[0]:
//    all channels clear remaining and busy, and set estop.
//   Latency from a gpi pin edge to busy=0 is at most 3 cycles.
// STRUCTURE
//  rtmc_pkg holds: register offsets, GPIO address, CTRL bit positions,
//   a typedef ctrl_t packed struct, the 8x4 phase-table constant, and a function next_idx().
//  Sub-module rtmc_step_chan: timer, count, position, index and status for one channel.
//   It is generated NCH times.
//  The top level holds the bus decode, read mux, ack, gpi synchroniser and e-stop edge detect.
// TESTING
//  1. Reset: all outputs 0; read 0xFF with gpi=4'h0 -> rdat 0x0000, ack 1 cycle after rd.
//  2. ch0 CTRL=0x4, PERIOD=3, COUNT=4.
//     -> 4 steps exactly 3 clk apart; mc 1000->0100->0010->0001->1000.
//     -> busy drops, done=1, irq=1. A STATUS read clears done.
//  3. ch1 half-step reverse (CTRL=0x7), PERIOD=1, COUNT=3.
//     -> a step every clk; idx 0->7->6->5; position 0xFFFD.
//  4. COUNT=100, then gpi[0] rises after step 10.
//     -> busy=0 within 3 clk; estop=1; done=0; remaining frozen at 0.
//  5. Wr and rd on the same cycle -> a single ack, rdat=0, write applied.
//     A COUNT write on the final-step cycle -> busy stays set.
//  6. rst asserted mid-move -> the next cycle shows mc=0, mc_oe=0, busy=0, position=0.

Source files
------------

// File: rtl/rtmc_pkg.sv
// Shared definitions for the multi-channel stepper controller: register map,
// CTRL layout, coil phase table and phase-index stepping.
package rtmc_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [7:0] ADDR_POS  = 8'hFE;
    localparam logic [7:0] ADDR_GPIO = 8'hFF;

    localparam int CTRL_DIR  = 0;
    localparam int CTRL_HALF = 1;
    localparam int CTRL_OE   = 2;
    localparam int CTRL_HOLD = 3;

    typedef struct packed {
        logic hold;
        logic oe;
        logic half;
        logic dir;
    } ctrl_t;

    // Index 0 is the rightmost entry: 1000,1100,0100,0110,0010,0011,0001,1001
    localparam logic [7:0][3:0] PHASE_TAB = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                            input logic dir,
                                            input logic half);
        logic [2:0] d;
        d = half ? 3'd1 : 3'd2;
        return dir ? idx - d : idx + d;
    endfunction

endpackage

// File: rtl/rtmc_step_chan.sv
// One motor channel: step timer, remaining-step count, signed position,
// phase index and busy/done/estop status.
module rtmc_step_chan
    import rtmc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ctrl,
    input  logic              wr_period,
    input  logic              wr_count,
    input  logic              wr_status,
    input  logic              rd_status,
    input  logic [DATA_W-1:0] wdat,
    input  logic              estop_evt,
    output ctrl_t             ctrl,
    output logic [DATA_W-1:0] period,
    output logic [DATA_W-1:0] remaining,
    output logic [DATA_W-1:0] position,
    output logic [DATA_W-1:0] status,
    output logic              done,
    output logic [3:0]        mc,
    output logic [3:0]        mc_oe
);

    logic [DATA_W-1:0] timer;
    logic [DATA_W-1:0] reload;
    logic [2:0]        idx;
    logic [2:0]        idx_mv;
    logic              busy;
    logic              estop;
    logic              step;
    logic              move;

    // PERIOD of 0 behaves like 1, so the reload value saturates at 0
    assign reload = (period == '0) ? '0 : period - DATA_W'(1);
    assign step   = busy && (timer == '0);
    assign move   = step && !estop_evt;
    assign idx_mv = move ? next_idx(idx, ctrl.dir, ctrl.half) : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl      <= '0;
            period    <= '0;
            remaining <= '0;
            position  <= '0;
            timer     <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            estop     <= 1'b0;
        end else begin
            // Clears come first so a same-cycle set event is never lost
            if (rd_status) begin
                done  <= 1'b0;
                estop <= 1'b0;
            end

            if (estop_evt) begin
                remaining <= '0;
                busy      <= 1'b0;
                estop     <= 1'b1;
            end else if (wr_count) begin
                remaining <= wdat;
                busy      <= (wdat != '0);
                timer     <= reload;
            end else if (step) begin
                remaining <= remaining - DATA_W'(1);
                timer     <= reload;
                if (remaining == DATA_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (busy) begin
                timer <= timer - DATA_W'(1);
            end

            idx <= (wr_ctrl && !wdat[CTRL_HALF]) ? {idx_mv[2:1], 1'b0} : idx_mv;

            if (wr_status)
                position <= '0;
            else if (move)
                position <= ctrl.dir ? position - DATA_W'(1) : position + DATA_W'(1);

            if (wr_ctrl) begin
                ctrl.dir  <= wdat[CTRL_DIR];
                ctrl.half <= wdat[CTRL_HALF];
                ctrl.oe   <= wdat[CTRL_OE];
                ctrl.hold <= wdat[CTRL_HOLD];
            end
            if (wr_period)
                period <= wdat;
        end
    end

    assign status = DATA_W'({idx, 2'b00, estop, done, busy});
    assign mc     = (busy || ctrl.hold) ? PHASE_TAB[idx] : 4'b0000;
    assign mc_oe  = {4{ctrl.oe}};

endmodule

// File: rtl/rtmc_mchan_ctrl.sv
// Multi-channel stepper controller: register decode, read mux, ack,
// gpi synchroniser with e-stop edge detect, and NCH step-engine channels.
module rtmc_mchan_ctrl
    import rtmc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int NCH    = 2,
    parameter int PH_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [DATA_W-1:0]   reg_wdat,
    input  logic                reg_wr,
    input  logic                reg_rd,
    output logic [DATA_W-1:0]   reg_rdat,
    output logic                reg_ack,
    input  logic [3:0]          gpi,
    output logic [3:0]          gpo,
    output logic [NCH*PH_W-1:0] mc,
    output logic [NCH*PH_W-1:0] mc_oe,
    output logic                irq
);

    logic [3:0]                   gpi_s1;
    logic [3:0]                   gpi_s2;
    logic                         estop_prev;
    logic                         estop_evt;
    logic [NCH-1:0][DATA_W-1:0]   ch_ctrl;
    logic [NCH-1:0][DATA_W-1:0]   ch_period;
    logic [NCH-1:0][DATA_W-1:0]   ch_rem;
    logic [NCH-1:0][DATA_W-1:0]   ch_pos;
    logic [NCH-1:0][DATA_W-1:0]   ch_status;
    logic [NCH-1:0]               ch_done;
    logic [ADDR_W-3:0]            ch_sel;
    logic [1:0]                   reg_off;
    logic                         rd_only;
    logic [DATA_W-1:0]            rd_mux;

    assign ch_sel    = reg_addr[ADDR_W-1:2];
    assign reg_off   = reg_addr[1:0];
    // A simultaneous write wins: no read side effects, rdat returns 0
    assign rd_only   = reg_rd && !reg_wr;
    assign estop_evt = gpi_s2[0] && !estop_prev;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic  hit;
        ctrl_t ctrl;

        assign hit = (ch_sel == (ADDR_W-2)'(c));

        rtmc_step_chan #(.DATA_W(DATA_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_ctrl   (reg_wr && hit && (reg_off == REG_CTRL)),
            .wr_period (reg_wr && hit && (reg_off == REG_PERIOD)),
            .wr_count  (reg_wr && hit && (reg_off == REG_COUNT)),
            .wr_status (reg_wr && hit && (reg_off == REG_STATUS)),
            .rd_status (rd_only && hit && (reg_off == REG_STATUS)),
            .wdat      (reg_wdat),
            .estop_evt (estop_evt),
            .ctrl      (ctrl),
            .period    (ch_period[c]),
            .remaining (ch_rem[c]),
            .position  (ch_pos[c]),
            .status    (ch_status[c]),
            .done      (ch_done[c]),
            .mc        (mc[c*PH_W +: PH_W]),
            .mc_oe     (mc_oe[c*PH_W +: PH_W])
        );

        assign ch_ctrl[c] = DATA_W'(ctrl);
    end

    always_comb begin
        rd_mux = '0;
        if (reg_addr == ADDR_W'(ADDR_GPIO)) begin
            rd_mux = DATA_W'({gpo, gpi_s2});
        end else if (reg_addr == ADDR_W'(ADDR_POS)) begin
            rd_mux = ch_pos[0];
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_sel == (ADDR_W-2)'(c)) begin
                    case (reg_off)
                        REG_CTRL:   rd_mux = ch_ctrl[c];
                        REG_PERIOD: rd_mux = ch_period[c];
                        REG_COUNT:  rd_mux = ch_rem[c];
                        default:    rd_mux = ch_status[c];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_ack    <= 1'b0;
            reg_rdat   <= '0;
            gpo        <= '0;
            gpi_s1     <= '0;
            gpi_s2     <= '0;
            estop_prev <= 1'b0;
        end else begin
            gpi_s1     <= gpi;
            gpi_s2     <= gpi_s1;
            estop_prev <= gpi_s2[0];
            reg_ack    <= reg_wr || reg_rd;
            reg_rdat   <= rd_only ? rd_mux : '0;
            if (reg_wr && (reg_addr == ADDR_W'(ADDR_GPIO)))
                gpo <= reg_wdat[3:0];
        end
    end

    assign irq = |ch_done;

endmodule

// File: tb/tb_rtmc_mchan_ctrl.sv
// Scoreboard bench for rtmc_mchan_ctrl: an event-scheduled reference model
// predicts every acked read and the coil/irq outputs on every cycle.
module tb_rtmc_mchan_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int NCH    = 2;
    localparam int PH_W   = 4;
    localparam int MAXC   = 32768;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [ADDR_W-1:0]   reg_addr = '0;
    logic [DATA_W-1:0]   reg_wdat = '0;
    logic                reg_wr = 1'b0;
    logic                reg_rd = 1'b0;
    logic [DATA_W-1:0]   reg_rdat;
    logic                reg_ack;
    logic [3:0]          gpi = 4'h0;
    logic [3:0]          gpo;
    logic [NCH*PH_W-1:0] mc;
    logic [NCH*PH_W-1:0] mc_oe;
    logic                irq;

    always #5 clk = ~clk;

    rtmc_mchan_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH), .PH_W(PH_W)) dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wdat(reg_wdat),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdat(reg_rdat), .reg_ack(reg_ack),
        .gpi(gpi), .gpo(gpo), .mc(mc), .mc_oe(mc_oe), .irq(irq)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit dir, half, oe, hold;
        int period, rem;
        bit busy, done, estop;
        int idx, pos, next_step;
    } ch_m_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } exp_t;

    logic [3:0] tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};
    ch_m_t      m [NCH];
    logic [3:0] gpo_m;
    logic [3:0] samp [MAXC];   // gpi value captured at each edge (0 on reset edges)
    bit         rs   [MAXC];   // edge had rst asserted
    int         cyc = 0;
    exp_t       sbq [$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // gpi as seen after two synchronising flops, just before edge e
    function automatic logic [3:0] sync_pre(input int e);
        if (e < 2 || rs[e-1]) return 4'h0;
        return samp[e-2];
    endfunction

    function automatic logic [3:0] prev_pre(input int e);
        if (e < 2 || rs[e-1]) return 4'h0;
        return sync_pre(e-1);
    endfunction

    function automatic logic [15:0] rd_model(input int a);
        logic [3:0] s;
        int c, r;
        if (a == 255) begin
            s = sync_pre(cyc);
            return {8'h00, gpo_m, s};
        end
        if (a == 254) return 16'(m[0].pos);
        if (a >= 4*NCH) return 16'h0;
        c = a / 4;
        r = a % 4;
        case (r)
            0:       return {12'h0, m[c].hold, m[c].oe, m[c].half, m[c].dir};
            1:       return 16'(m[c].period);
            2:       return 16'(m[c].rem);
            default: return {8'h0, 3'(m[c].idx), 2'b00, m[c].estop, m[c].done, m[c].busy};
        endcase
    endfunction

    task automatic model_edge();
        logic [3:0] s, p;
        bit   ev, hit, wsel, step;
        int   a, r, peff, d;
        ch_m_t o;
        cyc++;
        rs[cyc] = rst;
        if (rst) begin
            samp[cyc] = 4'h0;
            for (int c = 0; c < NCH; c++) m[c] = '{default: 0};
            gpo_m = 4'h0;
            return;
        end
        samp[cyc] = gpi;
        s  = sync_pre(cyc);
        p  = prev_pre(cyc);
        ev = s[0] && !p[0];
        a  = int'(reg_addr);
        if (reg_wr || reg_rd)
            sbq.push_back('{cyc, reg_wr ? 16'h0 : rd_model(a)});
        r = a % 4;
        for (int c = 0; c < NCH; c++) begin
            o    = m[c];
            hit  = (a < 4*NCH) && (a / 4 == c);
            wsel = reg_wr && hit;
            step = o.busy && (cyc == o.next_step);
            peff = (o.period == 0) ? 1 : o.period;
            if (reg_rd && !reg_wr && hit && r == 3) begin
                m[c].done  = 0;
                m[c].estop = 0;
            end
            if (ev) begin
                m[c].rem   = 0;
                m[c].busy  = 0;
                m[c].estop = 1;
            end else begin
                if (step) begin
                    d = o.half ? 1 : 2;
                    m[c].idx = o.dir ? (o.idx + 8 - d) % 8 : (o.idx + d) % 8;
                    m[c].pos = o.dir ? (o.pos + 65535) % 65536 : (o.pos + 1) % 65536;
                end
                if (wsel && r == 2) begin
                    m[c].rem       = int'(reg_wdat);
                    m[c].busy      = (reg_wdat != 0);
                    m[c].next_step = cyc + peff;
                end else if (step) begin
                    m[c].rem = o.rem - 1;
                    if (m[c].rem == 0) begin
                        m[c].busy = 0;
                        m[c].done = 1;
                    end else begin
                        m[c].next_step = cyc + peff;
                    end
                end
            end
            if (wsel && r == 0) begin
                m[c].dir  = reg_wdat[0];
                m[c].half = reg_wdat[1];
                m[c].oe   = reg_wdat[2];
                m[c].hold = reg_wdat[3];
                if (!reg_wdat[1]) m[c].idx = m[c].idx & 6;
            end
            if (wsel && r == 1) m[c].period = int'(reg_wdat);
            if (wsel && r == 3) m[c].pos = 0;
        end
        if (reg_wr && a == 255) gpo_m = reg_wdat[3:0];
    endtask

    // ---------------- monitor ----------------
    logic [NCH*PH_W-1:0] exp_mc, exp_oe;
    logic                exp_irq;
    exp_t                mon_e;

    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_mc  = '0;
            exp_oe  = '0;
            exp_irq = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                exp_mc[c*PH_W +: PH_W] = (m[c].busy || m[c].hold) ? tab[m[c].idx] : 4'h0;
                exp_oe[c*PH_W +: PH_W] = {4{m[c].oe}};
                exp_irq = exp_irq | m[c].done;
            end
            chk("mc", 32'(mc), 32'(exp_mc));
            chk("mc_oe", 32'(mc_oe), 32'(exp_oe));
            chk("irq", 32'(irq), 32'(exp_irq));
            chk("gpo", 32'(gpo), 32'(gpo_m));
            if (reg_ack) begin
                if (sbq.size() == 0) begin
                    chk("ack_unexpected", 32'(reg_ack), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("rdat", 32'(reg_rdat), 32'(mon_e.val));
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                mon_e = sbq.pop_front();
                chk("ack_missing", 32'(reg_ack), 32'd1);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        reg_wr = 1'b0;
        reg_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input int d);
        reg_addr = ADDR_W'(a);
        reg_wdat = DATA_W'(d);
        reg_wr   = 1'b1;
        tick();
    endtask

    task automatic rd(input int a);
        reg_addr = ADDR_W'(a);
        reg_rd   = 1'b1;
        tick();
    endtask

    task automatic wr_rd(input int a, input int d);
        reg_addr = ADDR_W'(a);
        reg_wdat = DATA_W'(d);
        reg_wr   = 1'b1;
        reg_rd   = 1'b1;
        tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    int op, ch, rg;

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            samp[i] = 4'h0;
            rs[i]   = 1'b1;
        end
        for (int c = 0; c < NCH; c++) m[c] = '{default: 0};
        gpo_m = 4'h0;

        // 1: reset state, GPIO read
        do_reset(3);
        idle(2);
        rd(255);
        idle(2);

        // 2: ch0 full-step forward, PERIOD 3, 4 steps, then done clear
        wr(0, 4'h4);
        wr(1, 3);
        wr(2, 4);
        idle(15);
        rd(3);
        rd(3);
        rd(254);

        // 3: ch1 half-step reverse, PERIOD 1, 3 steps
        wr(5, 1);
        wr(4, 4'h7);
        wr(6, 3);
        idle(5);
        rd(7);

        // 4: long move interrupted by e-stop
        wr(1, 2);
        wr(2, 100);
        idle(21);
        gpi = 4'h1;
        idle(5);
        rd(2);
        rd(3);
        rd(3);
        gpi = 4'h0;
        idle(3);

        // 5: simultaneous wr+rd; COUNT rewrite on the final-step cycle
        wr_rd(1, 1);
        rd(1);
        wr(2, 2);
        idle(1);
        wr(2, 3);
        rd(3);
        idle(6);
        rd(3);

        // 6: reset in the middle of a move
        wr(0, 4'hC);
        wr(1, 2);
        wr(2, 50);
        idle(5);
        do_reset(1);
        rd(3);
        rd(254);
        rd(0);

        // randomized traffic
        for (int it = 0; it < 2500; it++) begin
            op = $urandom_range(0, 99);
            ch = $urandom_range(0, NCH-1);
            rg = $urandom_range(0, 3);
            if (op < 35) begin
                case (rg)
                    0:       wr(4*ch, $urandom_range(0, 15));
                    1:       wr(4*ch + 1, $urandom_range(0, 4));
                    2:       wr(4*ch + 2, $urandom_range(0, 8));
                    default: wr(4*ch + 3, $urandom_range(0, 65535));
                endcase
            end else if (op < 60) begin
                rd(4*ch + rg);
            end else if (op < 64) begin
                rd($urandom_range(0, 1) ? 254 : 255);
            end else if (op < 67) begin
                rd($urandom_range(4*NCH, 253));
            end else if (op < 69) begin
                wr(255, $urandom_range(0, 15));
            end else if (op < 72) begin
                wr_rd(4*ch + rg, $urandom_range(0, 6));
            end else if (op < 76) begin
                gpi = 4'($urandom_range(0, 15));
                tick();
            end else if (op < 77) begin
                do_reset($urandom_range(1, 2));
            end else begin
                idle($urandom_range(1, 4));
            end
        end

        idle(4);
        if (sbq.size() != 0)
            chk("sbq_drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
